// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Four-state RV32 ALU sequencer driving an external combinational
//             ALU, with a 32 x 32 register file and single-cycle retire pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_res,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal
);

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_SLTU = 3'd6;
    localparam logic [2:0] ALU_MUL  = 3'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DEC  = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [31:0] r_instr;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [2:0]  r_alu_op;
    logic        r_illegal;
    logic [31:0] r_result;
    logic [31:0] r_regs [32];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic        w_f3_ok;
    logic [2:0]  w_f3_op;
    logic        w_legal;
    logic        w_use_imm;
    logic [2:0]  w_op;

    assign w_opcode  = r_instr[6:0];
    assign w_rd      = r_instr[11:7];
    assign w_funct3  = r_instr[14:12];
    assign w_rs1     = r_instr[19:15];
    assign w_rs2     = r_instr[24:20];
    assign w_funct7  = r_instr[31:25];
    assign w_imm     = {{20{r_instr[31]}}, r_instr[31:20]};
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

    // funct3 mapping shared by OP (funct7=0) and OP-IMM
    always_comb begin
        w_f3_ok = 1'b1;
        w_f3_op = ALU_ADD;
        case (w_funct3)
            3'b000:  w_f3_op = ALU_ADD;
            3'b100:  w_f3_op = ALU_XOR;
            3'b110:  w_f3_op = ALU_OR;
            3'b111:  w_f3_op = ALU_AND;
            3'b010:  w_f3_op = ALU_SLT;
            3'b011:  w_f3_op = ALU_SLTU;
            default: w_f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_legal   = 1'b0;
        w_use_imm = 1'b0;
        w_op      = ALU_ADD;
        if (w_opcode == OPC_OP) begin
            if (w_funct7 == 7'b0000000) begin
                w_legal = w_f3_ok;
                w_op    = w_f3_op;
            end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
                w_legal = 1'b1;
                w_op    = ALU_SUB;
            end else if (w_funct7 == 7'b0000001 && w_funct3 == 3'b000) begin
                w_legal = 1'b1;
                w_op    = ALU_MUL;
            end
        end else if (w_opcode == OPC_OP_IMM) begin
            w_legal   = w_f3_ok;
            w_op      = w_f3_op;
            w_use_imm = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next_state = S_DEC;
            S_DEC:   w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_WB;
            S_WB:    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr   <= 32'd0;
            r_alu_a   <= 32'd0;
            r_alu_b   <= 32'd0;
            r_alu_op  <= ALU_ADD;
            r_illegal <= 1'b0;
            r_result  <= 32'd0;
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else begin
            if (r_state == S_IDLE && in_valid) r_instr <= in_instr;
            if (r_state == S_DEC) begin
                r_alu_op  <= w_legal ? w_op : ALU_ADD;
                r_alu_a   <= w_legal ? w_rs1_val : 32'd0;
                r_alu_b   <= w_legal ? (w_use_imm ? w_imm : w_rs2_val) : 32'd0;
                r_illegal <= ~w_legal;
            end
            if (r_state == S_EXEC) r_result <= alu_res;
            if (r_state == S_WB && !r_illegal && w_rd != 5'd0) r_regs[w_rd] <= r_result;
        end
    end

    always_comb begin
        in_ready = (r_state == S_IDLE);
        wb_valid = (r_state == S_WB);
        illegal  = (r_state == S_WB) && r_illegal;
        wb_rd    = (r_state == S_WB) ? w_rd : 5'd0;
        wb_data  = (r_state == S_WB && !r_illegal) ? r_result : 32'd0;
    end

    assign alu_a  = r_alu_a;
    assign alu_b  = r_alu_b;
    assign alu_op = r_alu_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Directed self-checking bench for alu_seq with an ALU model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [2:0]  alu_op;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .illegal(illegal)
    );

    // External combinational ALU
    always_comb begin
        alu_res = 32'd0;
        case (alu_op)
            3'd0: alu_res = alu_a + alu_b;
            3'd1: alu_res = alu_a - alu_b;
            3'd2: alu_res = alu_a & alu_b;
            3'd3: alu_res = alu_a | alu_b;
            3'd4: alu_res = alu_a ^ alu_b;
            3'd5: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'd6: alu_res = {31'd0, alu_a < alu_b};
            3'd7: alu_res = alu_a * alu_b;
            default: alu_res = 32'd0;
        endcase
    end

    // Offer one instruction, then wait (bounded) for its retire pulse
    task automatic run_instr(input logic [31:0] instr, output int lat,
                             output logic [4:0] rd, output logic [31:0] data,
                             output logic ill, output logic rdy_after);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        in_instr = instr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = 32'hDEAD_BEEF;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!wb_valid && lat < 10);
        rd   = wb_rd;
        data = wb_data;
        ill  = illegal;
        @(negedge clk);
        rdy_after = in_ready;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl ready=%b wb_valid=%b illegal=%b exp 1/0/0",
                     in_ready, wb_valid, illegal);
        end
        n_cmp++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0 ||
            wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_data a=%h b=%h op=%0d rd=%0d data=%h exp all zero",
                     alu_a, alu_b, alu_op, wb_rd, wb_data);
        end
    endtask

    task automatic test_arith();
        logic [31:0] ins [7] = '{32'h00500093, 32'hFFD00113, 32'h402081B3,
                                 32'h00112233, 32'h001132B3, 32'h02208333,
                                 32'h00F17493};
        logic [31:0] exp [7] = '{32'h00000005, 32'hFFFFFFFD, 32'h00000008,
                                 32'h00000001, 32'h00000000, 32'hFFFFFFF1,
                                 32'h0000000D};
        logic [4:0]  erd [7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd9};
        int lat;
        logic [4:0] rd;
        logic [31:0] data;
        logic ill, rdy;
        for (int i = 0; i < 7; i++) begin
            run_instr(ins[i], lat, rd, data, ill, rdy);
            n_cmp++;
            if (data !== exp[i] || rd !== erd[i] || ill !== 1'b0) begin
                n_bad++;
                $display("FAIL arith_%0d rd=%0d data=%h ill=%b exp rd=%0d data=%h ill=0",
                         i, rd, data, ill, erd[i], exp[i]);
            end
            n_cmp++;
            if (lat !== 3 || rdy !== 1'b1) begin
                n_bad++;
                $display("FAIL arith_lat_%0d lat=%0d ready_after=%b exp 3/1", i, lat, rdy);
            end
        end
    endtask

    task automatic test_x0();
        int lat;
        logic [4:0] rd;
        logic [31:0] data;
        logic ill, rdy;
        run_instr(32'h00700013, lat, rd, data, ill, rdy);
        n_cmp++;
        if (lat !== 3 || rd !== 5'd0 || data !== 32'd7) begin
            n_bad++;
            $display("FAIL x0_write lat=%0d rd=%0d data=%h exp 3/0/00000007", lat, rd, data);
        end
        run_instr(32'h000003B3, lat, rd, data, ill, rdy);
        n_cmp++;
        if (rd !== 5'd7 || data !== 32'd0) begin
            n_bad++;
            $display("FAIL x0_read rd=%0d data=%h exp 7/00000000", rd, data);
        end
    endtask

    task automatic test_illegal();
        int lat;
        logic [4:0] rd;
        logic [31:0] data;
        logic ill, rdy;
        run_instr(32'h00209093, lat, rd, data, ill, rdy);
        n_cmp++;
        if (lat !== 3 || ill !== 1'b1 || rd !== 5'd1 || data !== 32'd0) begin
            n_bad++;
            $display("FAIL illegal_slli lat=%0d ill=%b rd=%0d data=%h exp 3/1/1/0",
                     lat, ill, rd, data);
        end
        run_instr(32'h00008433, lat, rd, data, ill, rdy);
        n_cmp++;
        if (ill !== 1'b0 || rd !== 5'd8 || data !== 32'd5) begin
            n_bad++;
            $display("FAIL illegal_after ill=%b rd=%0d data=%h exp 0/8/00000005",
                     ill, rd, data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [3] = '{32'h00100513, 32'h00200593, 32'h00300613};
        logic [31:0] got [4];
        logic [4:0]  grd [4];
        int idx = 0, nwb = 0, nrdy = 0;
        logic rdy;
        @(negedge clk);
        in_instr = prog[0];
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            rdy = in_ready;
            if (rdy) nrdy++;
            if (wb_valid && nwb < 4) begin
                got[nwb] = wb_data;
                grd[nwb] = wb_rd;
                nwb++;
            end
            @(posedge clk);
            #1;
            if (rdy && in_valid) begin
                idx++;
                if (idx < 3) in_instr = prog[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (nrdy !== 3 || nwb !== 3) begin
            n_bad++;
            $display("FAIL b2b_counts ready_cycles=%0d retired=%0d exp 3/3", nrdy, nwb);
        end
        for (int i = 0; i < 3 && i < nwb; i++) begin
            n_cmp++;
            if (got[i] !== 32'(i + 1) || grd[i] !== 5'(10 + i)) begin
                n_bad++;
                $display("FAIL b2b_%0d rd=%0d data=%h exp rd=%0d data=%h",
                         i, grd[i], got[i], 10 + i, i + 1);
            end
        end
    endtask

    task automatic test_mid_reset();
        int lat, nwb = 0, guard = 0;
        logic [4:0] rd;
        logic [31:0] data;
        logic ill, rdy;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        in_instr = 32'h001080B3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        if (wb_valid) nwb++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            n_bad++;
            $display("FAIL midrst_state ready=%b wb_valid=%b a=%h b=%h exp 1/0/0/0",
                     in_ready, wb_valid, alu_a, alu_b);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wb_valid) nwb++;
        end
        rst_n = 1'b1;
        n_cmp++;
        if (nwb !== 0) begin
            n_bad++;
            $display("FAIL midrst_wb wb_pulses=%0d exp 0", nwb);
        end
        run_instr(32'h00008433, lat, rd, data, ill, rdy);
        n_cmp++;
        if (lat !== 3 || rd !== 5'd8 || data !== 32'd0) begin
            n_bad++;
            $display("FAIL midrst_x1 lat=%0d rd=%0d data=%h exp 3/8/00000000", lat, rd, data);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_arith();
        test_x0();
        test_illegal();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
